transpose_bank_controller: RTL

- Sequences two ping-pong sets of NUM_PE transpose memory banks. Each set holds one NUM_PE x NUM_PE matrix; each bank is NUM_PE deep.
- Accepts matrix rows on a valid/ready stream and writes them with diagonal skew.
- Generates per-bank read addresses so each output beat is one column of the stored matrix, which makes it one row of the transpose.
- Drives the rotation selects for the external input and output lane crossbars. One set fills while the other drains.

---
 rtl/transpose_bank_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/transpose_bank_controller.sv
// Ping-pong transpose bank sequencer: skewed row writes, look-ahead column reads.
// Optional stall counters are enabled with `define TRANSPOSE_CTRL_PERF_EN.
module transpose_bank_controller #(
  parameter  int NUM_PE     = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_PE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [ADDR_WIDTH-1:0]          wr_rot,
  output logic [ADDR_WIDTH-1:0]          rd_rot,
  output logic                           rd_buf_sel,
  output logic [NUM_PE-1:0]              we0,
  output logic [NUM_PE-1:0]              we1,
  output logic [NUM_PE*ADDR_WIDTH-1:0]   waddr0,
  output logic [NUM_PE*ADDR_WIDTH-1:0]   waddr1,
  output logic [NUM_PE*ADDR_WIDTH-1:0]   raddr0,
  output logic [NUM_PE*ADDR_WIDTH-1:0]   raddr1
`ifdef TRANSPOSE_CTRL_PERF_EN
  ,
  output logic [31:0]                    in_stall_cnt,
  output logic [31:0]                    out_stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_PE - 1);
  localparam logic [ADDR_WIDTH-1:0] LSB_ONE  = ADDR_WIDTH'(1);

  logic                  r_wr_buf;
  logic [ADDR_WIDTH-1:0] r_wr_row;
  logic [1:0]            r_full;
  logic                  r_rd_buf;
  logic [ADDR_WIDTH-1:0] r_rd_row;
  state_t                r_state;

  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic [1:0]            w_full_nxt;
  logic [1:0]            w_wr_set;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] w_next_row;
  logic                  w_next_buf;
  logic [ADDR_WIDTH-1:0] w_ra;

  assign in_ready   = !r_full[r_wr_buf];
  assign w_wr_fire  = in_valid && in_ready;
  assign out_valid  = (r_state == S_ACTIVE);
  assign w_rd_fire  = out_valid && out_ready;
  assign w_wr_done  = w_wr_fire && (r_wr_row == LAST_ROW);
  assign w_rd_done  = w_rd_fire && (r_rd_row == LAST_ROW);
  assign wr_rot     = r_wr_row;
  assign rd_rot     = r_rd_row;
  assign rd_buf_sel = r_rd_buf;
  assign out_last   = out_valid && (r_rd_row == LAST_ROW);
  // A set is write-owned only while it is not full; a full set belongs to the reader.
  assign w_wr_set   = {r_wr_buf && in_ready, !r_wr_buf && in_ready};

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_buf] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_buf] = 1'b0;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_row   = r_rd_row;
    w_next_buf   = r_rd_buf;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_buf]) begin
          w_next_state = S_ACTIVE;
          w_next_row   = '0;
        end
      end
      S_ACTIVE: begin
        if (w_rd_fire) begin
          if (r_rd_row == LAST_ROW) begin
            w_next_buf   = !r_rd_buf;
            w_next_row   = '0;
            w_next_state = r_full[!r_rd_buf] ? S_ACTIVE : S_IDLE;
          end else begin
            w_next_row = r_rd_row + 1'b1;
          end
        end
      end
    endcase
  end

  // Read addresses lead the registered row by one cycle to cover bank read latency;
  // non-written sets get raddr^1 on the write port so bank forwarding never hits.
  always_comb begin
    we0    = {NUM_PE{w_wr_fire && !r_wr_buf}};
    we1    = {NUM_PE{w_wr_fire && r_wr_buf}};
    raddr0 = '0;
    raddr1 = '0;
    waddr0 = '0;
    waddr1 = '0;
    w_ra   = '0;
    for (int unsigned b = 0; b < NUM_PE; b++) begin
      w_ra = ADDR_WIDTH'(b) - w_next_row;
      if (w_next_state == S_ACTIVE) begin
        if (w_next_buf) raddr1[b*ADDR_WIDTH +: ADDR_WIDTH] = w_ra;
        else            raddr0[b*ADDR_WIDTH +: ADDR_WIDTH] = w_ra;
      end
      waddr0[b*ADDR_WIDTH +: ADDR_WIDTH] = w_wr_set[0] ? r_wr_row
                                         : (raddr0[b*ADDR_WIDTH +: ADDR_WIDTH] ^ LSB_ONE);
      waddr1[b*ADDR_WIDTH +: ADDR_WIDTH] = w_wr_set[1] ? r_wr_row
                                         : (raddr1[b*ADDR_WIDTH +: ADDR_WIDTH] ^ LSB_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_buf <= 1'b0;
      r_wr_row <= '0;
      r_full   <= '0;
      r_rd_buf <= 1'b0;
      r_rd_row <= '0;
      r_state  <= S_IDLE;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (r_wr_row == LAST_ROW) begin
          r_wr_row <= '0;
          r_wr_buf <= !r_wr_buf;
        end else begin
          r_wr_row <= r_wr_row + 1'b1;
        end
      end
      r_state  <= w_next_state;
      r_rd_row <= w_next_row;
      r_rd_buf <= w_next_buf;
    end
  end

`ifdef TRANSPOSE_CTRL_PERF_EN
  logic [31:0] r_in_stall_cnt;
  logic [31:0] r_out_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_stall_cnt  <= '0;
      r_out_stall_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (r_in_stall_cnt != '1))
        r_in_stall_cnt <= r_in_stall_cnt + 1'b1;
      if (out_valid && !out_ready && (r_out_stall_cnt != '1))
        r_out_stall_cnt <= r_out_stall_cnt + 1'b1;
    end
  end

  assign in_stall_cnt  = r_in_stall_cnt;
  assign out_stall_cnt = r_out_stall_cnt;
`endif

endmodule
